// File: rtl/exp2_lms_if.sv
// Valid/ready stream bundle used on both sides of the exp2_lms antilog unit.
// master drives valid/data and samples ready; slave does the reverse.
interface exp2_lms_if #(
    parameter int unsigned DATA_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/exp2_lms.sv
// exp2_lms: 2^x antilog unit for the lab->RGB return path.
// Input is unsigned 3.13 log2 value {integ, frac}; output is unsigned 8.8 linear value.
// Three-stage valid/ready pipeline: capture -> mantissa (LUT + interpolation) -> scale.
// Build option: define EXP2_ROUND_EN to round-to-nearest in the scale stage instead of
// truncating (saturating at 0xFFFF); latency and handshake are unchanged.
module exp2_lms (
    input  logic      i_clk,
    input  logic      i_rst_n,
    exp2_lms_if.slave  i_log2_if,
    exp2_lms_if.master o_lin_if
);
    localparam int unsigned LUT_BITS = 5;
    localparam int unsigned INTERP_W = 8;

    // T[k] = round(32768 * 2^(k/32)) in 1.15; T[32] = 2.0 closes the last segment
    function automatic logic [16:0] f_tab(input logic [LUT_BITS:0] idx);
        logic [16:0] t;
        case (idx)
            6'd0:    t = 17'd32768;
            6'd1:    t = 17'd33486;
            6'd2:    t = 17'd34219;
            6'd3:    t = 17'd34968;
            6'd4:    t = 17'd35734;
            6'd5:    t = 17'd36516;
            6'd6:    t = 17'd37316;
            6'd7:    t = 17'd38133;
            6'd8:    t = 17'd38968;
            6'd9:    t = 17'd39821;
            6'd10:   t = 17'd40693;
            6'd11:   t = 17'd41584;
            6'd12:   t = 17'd42495;
            6'd13:   t = 17'd43425;
            6'd14:   t = 17'd44376;
            6'd15:   t = 17'd45348;
            6'd16:   t = 17'd46341;
            6'd17:   t = 17'd47356;
            6'd18:   t = 17'd48393;
            6'd19:   t = 17'd49452;
            6'd20:   t = 17'd50535;
            6'd21:   t = 17'd51642;
            6'd22:   t = 17'd52773;
            6'd23:   t = 17'd53928;
            6'd24:   t = 17'd55109;
            6'd25:   t = 17'd56316;
            6'd26:   t = 17'd57549;
            6'd27:   t = 17'd58809;
            6'd28:   t = 17'd60097;
            6'd29:   t = 17'd61413;
            6'd30:   t = 17'd62757;
            6'd31:   t = 17'd64132;
            default: t = 17'd65536;
        endcase
        return t;
    endfunction

    // Stage registers
    logic                r_v1, r_v2, r_v3;
    logic [2:0]          r_i1, r_i2;
    logic [LUT_BITS-1:0] r_k1;
    logic [INTERP_W-1:0] r_r1;
    logic [16:0]         r_m2;
    logic [15:0]         r_lin3;

    // Handshake and datapath wires
    logic        w_rdy1, w_rdy2, w_rdy3;
    logic [16:0] w_t0, w_t1;
    logic [10:0] w_d;
    logic [18:0] w_prod;
    logic [16:0] w_m;
    logic [2:0]  w_sh;
    logic [15:0] w_lin;
`ifdef EXP2_ROUND_EN
    logic [17:0] w_sum;
    logic [17:0] w_rnd;
`endif

    // Ready ripples back from the output; a stage can load if empty or draining
    always_comb begin
        w_rdy3 = !r_v3 || o_lin_if.ready;
        w_rdy2 = !r_v2 || w_rdy3;
        w_rdy1 = !r_v1 || w_rdy2;
    end

    assign i_log2_if.ready = w_rdy1;
    assign o_lin_if.valid  = r_v3;
    assign o_lin_if.data   = r_lin3;

    // Mantissa: table lookup with linear interpolation toward the next entry
    always_comb begin
        w_t0   = f_tab({1'b0, r_k1});
        w_t1   = f_tab({1'b0, r_k1} + 6'd1);
        w_d    = 11'(w_t1 - w_t0);
        w_prod = {8'd0, w_d} * {11'd0, r_r1};
        w_m    = w_t0 + {6'd0, 11'(w_prod >> INTERP_W)};
    end

    // Scale: m is 1.15, so integ = 7 needs no shift to land in 8.8
    always_comb begin
        w_sh  = 3'd7 - r_i2;
`ifdef EXP2_ROUND_EN
        w_sum = {1'b0, r_m2} + (18'd1 << (w_sh - 3'd1));
        w_rnd = w_sum >> w_sh;
        if (w_sh == 3'd0) begin
            w_lin = 16'(r_m2);
        end else if (|w_rnd[17:16]) begin
            w_lin = 16'hFFFF;
        end else begin
            w_lin = w_rnd[15:0];
        end
`else
        w_lin = 16'(r_m2 >> w_sh);
`endif
    end

    // S1: capture integer part, LUT index and interpolation fraction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1 <= 1'b0;
            r_i1 <= '0;
            r_k1 <= '0;
            r_r1 <= '0;
        end else if (w_rdy1) begin
            r_v1 <= i_log2_if.valid;
            if (i_log2_if.valid) begin
                r_i1 <= i_log2_if.data[15:13];
                r_k1 <= i_log2_if.data[12:8];
                r_r1 <= i_log2_if.data[7:0];
            end
        end
    end

    // S2: register interpolated mantissa alongside the octave
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v2 <= 1'b0;
            r_i2 <= '0;
            r_m2 <= '0;
        end else if (w_rdy2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_i2 <= r_i1;
                r_m2 <= w_m;
            end
        end
    end

    // S3: register scaled output; holds while downstream stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v3   <= 1'b0;
            r_lin3 <= '0;
        end else if (w_rdy3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_lin3 <= w_lin;
            end
        end
    end
endmodule
